// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - two-state fetch/present PC unit feeding a single-issue decode stage
// Holds one fetched instruction until consumed, then redirects the PC by jr/jump/branch/sequential.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump_en,
  input  logic [27:0] jump_target,
  input  logic        branch_en,
  input  logic [31:0] branch_offset,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misalign
);

  typedef enum logic {
    FETCH   = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        req_q;
  logic        consume;
  logic        jr_misaligned;
  logic [31:0] next_pc;

  assign consume       = (state == PRESENT) && !stall;
  assign jr_misaligned = jr_en && (jr_addr[1:0] != 2'b00);

  always_comb begin
    next_pc = pc_plus4;
    if (jr_en) begin
      next_pc = {jr_addr[31:2], 2'b00};
    end else if (jump_en) begin
      next_pc = {pc_plus4[31:28], jump_target};
    end else if (branch_en) begin
      next_pc = pc_plus4 + branch_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      req_q       <= 1'b1;
      instr       <= 32'h0000_0000;
      instr_pc    <= 32'h0000_0000;
      pc_plus4    <= 32'h0000_0000;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            pc_plus4    <= pc + 32'd4;
            instr_valid <= 1'b1;
            req_q       <= 1'b0;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          // Late acks are dropped here; only a consume moves the unit on.
          if (consume) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            req_q       <= 1'b1;
            misalign    <= jr_misaligned;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Gate with rst so no request escapes during the reset cycle itself.
  assign imem_req  = req_q & ~rst;
  assign imem_addr = pc;

endmodule
